// File: rtl/ysyx_22050550_trap_pkg.sv
// Shared encodings for the trap controller: states, trap kinds, CSR
// write-enable bit positions, mstatus/mie bit indices and cause codes.
package ysyx_22050550_trap_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRAIN,
    S_COMMIT,
    S_REDIRECT
  } trap_state_e;

  typedef enum logic [1:0] {
    K_NONE,
    K_ECALL,
    K_MRET,
    K_IRQ
  } trap_kind_e;

  localparam int CSR_MEPC    = 0;
  localparam int CSR_MCAUSE  = 1;
  localparam int CSR_MTVEC   = 2;
  localparam int CSR_MSTATUS = 3;
  localparam int CSR_MIE     = 4;
  localparam int CSR_MIP     = 5;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam int MIE_MTIE     = 7;

  localparam int ECALL_CODE = 11;
  localparam int TIMER_CODE = 7;

endpackage

// File: rtl/ysyx_22050550_trap_mstatus_upd.sv
// mstatus update on trap entry (MPIE<=MIE, MIE<=0) or mret (MIE<=MPIE, MPIE<=1).
module ysyx_22050550_trap_mstatus_upd
  import ysyx_22050550_trap_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] mstatus_i,
  input  logic            mret_i,
  output logic [XLEN-1:0] mstatus_o
);

  always_comb begin
    mstatus_o = mstatus_i;
    if (mret_i) begin
      mstatus_o[MSTATUS_MIE]  = mstatus_i[MSTATUS_MPIE];
      mstatus_o[MSTATUS_MPIE] = 1'b1;
    end else begin
      mstatus_o[MSTATUS_MPIE] = mstatus_i[MSTATUS_MIE];
      mstatus_o[MSTATUS_MIE]  = 1'b0;
    end
  end

endmodule

// File: rtl/ysyx_22050550_trap.sv
// Trap entry/exit sequencer at the commit boundary (ecall, mret, timer irq).
// Define YSYX_22050550_TRAP_VECTORED_EN to enable vectored interrupt targets.
module ysyx_22050550_trap_ctrl
  import ysyx_22050550_trap_pkg::*;
#(
  parameter int XLEN         = 64,
  parameter int FLUSH_CYCLES = 2,
  parameter int ECALL_CAUSE  = ECALL_CODE,
  parameter int TIMER_CAUSE  = TIMER_CODE
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            wb_valid,
  input  logic [XLEN-1:0] wb_pc,
  input  logic [XLEN-1:0] wb_nextpc,
  input  logic            wb_ecall,
  input  logic            wb_mret,
  output logic            wb_ready,
  input  logic            timer_irq,
  input  logic [XLEN-1:0] mstatus,
  input  logic [XLEN-1:0] mie,
  input  logic [XLEN-1:0] mtvec,
  input  logic [XLEN-1:0] mepc,
  input  logic            lsu_busy,
  output logic            flush,
  output logic [7:0]      csr_wen,
  output logic [XLEN-1:0] csr_mepc,
  output logic [XLEN-1:0] csr_mcause,
  output logic [XLEN-1:0] csr_mstatus,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  input  logic            redirect_ready,
  output logic            busy
);

  trap_state_e     state_q, state_d;
  trap_kind_e      kind_q, kind_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic [XLEN-1:0] cause_q, cause_d;
  logic [XLEN-1:0] tgt_q, tgt_d;
  logic [3:0]      cnt_q, cnt_d;

  logic            irq_pend;
  logic            is_mret;
  logic [XLEN-1:0] base;
  logic [XLEN-1:0] trap_tgt;
  logic [XLEN-1:0] mstatus_new;
  logic            unused_ok;

  assign irq_pend = timer_irq & mstatus[MSTATUS_MIE] & mie[MIE_MTIE];
  assign is_mret  = (kind_q == K_MRET);
  assign base     = {mtvec[XLEN-1:2], 2'b00};

`ifdef YSYX_22050550_TRAP_VECTORED_EN
  assign trap_tgt = (mtvec[1:0] == 2'b01 && kind_q == K_IRQ)
                  ? base + XLEN'(4 * TIMER_CAUSE)
                  : base;
`else
  assign trap_tgt = base;
`endif

  assign unused_ok = ^{mie[XLEN-1:MIE_MTIE+1], mie[MIE_MTIE-1:0], mtvec[1:0]};

  ysyx_22050550_trap_mstatus_upd #(.XLEN(XLEN)) u_mstatus_upd (
    .mstatus_i (mstatus),
    .mret_i    (is_mret),
    .mstatus_o (mstatus_new)
  );

  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    epc_d   = epc_q;
    cause_d = cause_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (wb_valid && (wb_ecall || wb_mret || irq_pend)) begin
          state_d = S_DRAIN;
          cnt_d   = 4'(FLUSH_CYCLES - 1);
          if (wb_ecall) begin
            kind_d  = K_ECALL;
            epc_d   = wb_pc;
            cause_d = XLEN'(ECALL_CAUSE);
          end else if (wb_mret) begin
            kind_d  = K_MRET;
          end else begin
            kind_d  = K_IRQ;
            epc_d   = wb_nextpc;
            cause_d = {1'b1, (XLEN-1)'(TIMER_CAUSE)};
          end
        end
      end
      S_DRAIN: begin
        if (cnt_q == 4'd0 && !lsu_busy) state_d = S_COMMIT;
        else if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
      end
      S_COMMIT: begin
        tgt_d   = is_mret ? mepc : trap_tgt;
        state_d = S_REDIRECT;
      end
      S_REDIRECT: begin
        if (redirect_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      kind_q  <= K_NONE;
      epc_q   <= '0;
      cause_q <= '0;
      tgt_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      epc_q   <= epc_d;
      cause_q <= cause_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs decode from state and latched data only, never from wb_*.
  always_comb begin
    wb_ready       = (state_q == S_IDLE);
    busy           = (state_q != S_IDLE);
    flush          = (state_q == S_DRAIN) || (state_q == S_COMMIT);
    redirect_valid = (state_q == S_REDIRECT);
    redirect_pc    = (state_q == S_REDIRECT) ? tgt_q : '0;
    csr_wen        = '0;
    csr_mepc       = '0;
    csr_mcause     = '0;
    csr_mstatus    = '0;
    if (state_q == S_COMMIT) begin
      csr_wen[CSR_MSTATUS] = 1'b1;
      csr_mstatus          = mstatus_new;
      if (!is_mret) begin
        csr_wen[CSR_MEPC]   = 1'b1;
        csr_wen[CSR_MCAUSE] = 1'b1;
        csr_mepc            = epc_q;
        csr_mcause          = cause_q;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_22050550_trap_ctrl.sv
// Scoreboard bench for ysyx_22050550_trap_ctrl: expected CSR commits and
// redirect targets are queued at issue and checked when the DUT emits them.
module tb_ysyx_22050550_trap_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        wb_valid, wb_ecall, wb_mret, wb_ready;
  logic [63:0] wb_pc, wb_nextpc;
  logic        timer_irq, lsu_busy;
  logic [63:0] mstatus, mie, mtvec, mepc;
  logic        flush, redirect_valid, redirect_ready, busy;
  logic [7:0]  csr_wen;
  logic [63:0] csr_mepc, csr_mcause, csr_mstatus, redirect_pc;

  typedef struct {
    logic [7:0]  wen;
    logic [63:0] mepc;
    logic [63:0] mcause;
    logic [63:0] mstatus;
    logic [63:0] tgt;
  } exp_t;

  exp_t        commit_q[$];
  logic [63:0] redir_q[$];
  int          n_chk  = 0;
  int          n_fail = 0;
  int          n_redir = 0;

  ysyx_22050550_trap_ctrl dut (
    .clock          (clock),
    .reset          (reset),
    .wb_valid       (wb_valid),
    .wb_pc          (wb_pc),
    .wb_nextpc      (wb_nextpc),
    .wb_ecall       (wb_ecall),
    .wb_mret        (wb_mret),
    .wb_ready       (wb_ready),
    .timer_irq      (timer_irq),
    .mstatus        (mstatus),
    .mie            (mie),
    .mtvec          (mtvec),
    .mepc           (mepc),
    .lsu_busy       (lsu_busy),
    .flush          (flush),
    .csr_wen        (csr_wen),
    .csr_mepc       (csr_mepc),
    .csr_mcause     (csr_mcause),
    .csr_mstatus    (csr_mstatus),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .redirect_ready (redirect_ready),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clock) begin
    if (!reset) begin
      if (csr_wen != 8'h00) begin
        if (commit_q.size() == 0) begin
          check("commit_unexpected", {56'd0, csr_wen}, 64'd0);
        end else begin
          exp_t e;
          e = commit_q.pop_front();
          check("csr_wen", {56'd0, csr_wen}, {56'd0, e.wen});
          check("csr_mepc", csr_mepc, e.mepc);
          check("csr_mcause", csr_mcause, e.mcause);
          check("csr_mstatus", csr_mstatus, e.mstatus);
          check("commit_flush", {63'd0, flush}, 64'd1);
          redir_q.push_back(e.tgt);
        end
      end
      if (redirect_valid && redirect_ready) begin
        n_redir++;
        if (redir_q.size() == 0)
          check("redir_unexpected", {63'd0, redirect_valid}, 64'd0);
        else
          check("redirect_pc", redirect_pc, redir_q.pop_front());
      end
    end
  end

  task automatic issue(input logic e, input logic m,
                       input logic [63:0] pc, input logic [63:0] npc);
    @(posedge clock); #1;
    wb_valid = 1'b1; wb_ecall = e; wb_mret = m;
    wb_pc = pc; wb_nextpc = npc;
    @(posedge clock); #1;
    wb_valid = 1'b0; wb_ecall = 1'b0; wb_mret = 1'b0;
  endtask

  task automatic wait_idle(output int busy_n, output int flush_n);
    bit done;
    done = 0; busy_n = 0; flush_n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (!busy) begin
        done = 1;
        break;
      end
      busy_n++;
      if (flush) flush_n++;
    end
    if (!done) check("idle_timeout", {63'd0, busy}, 64'd0);
  endtask

  int bn, fn, snap;
  logic [63:0] vec_exp;

  initial begin
    reset = 1'b1;
    wb_valid = 0; wb_ecall = 0; wb_mret = 0;
    wb_pc = 0; wb_nextpc = 0; timer_irq = 0; lsu_busy = 0;
    mstatus = 0; mie = 0; mtvec = 0; mepc = 0;
    redirect_ready = 1'b1;

    repeat (2) @(negedge clock);
    check("rst_wb_ready", {63'd0, wb_ready}, 64'd1);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_flush", {63'd0, flush}, 64'd0);
    check("rst_csr_wen", {56'd0, csr_wen}, 64'd0);
    check("rst_rvalid", {63'd0, redirect_valid}, 64'd0);
    check("rst_rpc", redirect_pc, 64'd0);
    @(posedge clock); #1 reset = 1'b0;

    // ecall, best-case latency
    mstatus = 64'h8; mtvec = 64'h80001000;
    commit_q.push_back('{8'h0B, 64'h80000010, 64'd11, 64'h80, 64'h80001000});
    issue(1'b1, 1'b0, 64'h80000010, 64'h80000014);
    wait_idle(bn, fn);
    check("ecall_flush_cycles", 64'(fn), 64'd3);
    check("ecall_busy_cycles", 64'(bn), 64'd4);
    check("ecall_wb_ready", {63'd0, wb_ready}, 64'd1);

    // mret
    mstatus = 64'h80; mepc = 64'h80000014;
    commit_q.push_back('{8'h08, 64'd0, 64'd0, 64'h88, 64'h80000014});
    issue(1'b0, 1'b1, 64'h80000030, 64'h80000034);
    wait_idle(bn, fn);
    check("mret_busy_cycles", 64'(bn), 64'd4);

    // timer interrupt
    mstatus = 64'h8; mie = 64'h80; timer_irq = 1'b1;
    commit_q.push_back('{8'h0B, 64'h80000104, 64'h8000000000000007,
                         64'h80, 64'h80001000});
    issue(1'b0, 1'b0, 64'h80000100, 64'h80000104);
    wait_idle(bn, fn);
    check("irq_busy_cycles", 64'(bn), 64'd4);

    // interrupt masked by mie
    mie = 64'h0;
    issue(1'b0, 1'b0, 64'h80000200, 64'h80000204);
    @(negedge clock);
    check("irq_masked_busy", {63'd0, busy}, 64'd0);
    check("irq_masked_wb_ready", {63'd0, wb_ready}, 64'd1);

    // ecall beats pending interrupt
    mie = 64'h80;
    commit_q.push_back('{8'h0B, 64'h80000300, 64'd11, 64'h80, 64'h80001000});
    issue(1'b1, 1'b0, 64'h80000300, 64'h80000304);
    wait_idle(bn, fn);
    timer_irq = 1'b0;

    // LSU drain stall and redirect backpressure
    lsu_busy = 1'b1; redirect_ready = 1'b0;
    commit_q.push_back('{8'h0B, 64'h80000020, 64'd11, 64'h80, 64'h80001000});
    snap = n_redir;
    issue(1'b1, 1'b0, 64'h80000020, 64'h80000024);
    repeat (5) @(posedge clock);
    #1 lsu_busy = 1'b0;
    @(negedge clock);
    check("stall_still_drain", {56'd0, csr_wen}, 64'd0);
    check("stall_flush", {63'd0, flush}, 64'd1);
    @(negedge clock);
    check("stall_commit_now", {56'd0, csr_wen}, 64'h0B);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("bp_rvalid", {63'd0, redirect_valid}, 64'd1);
      check("bp_rpc_stable", redirect_pc, 64'h80001000);
      check("bp_flush", {63'd0, flush}, 64'd0);
    end
    @(posedge clock); #1 redirect_ready = 1'b1;
    wait_idle(bn, fn);
    check("bp_single_accept", 64'(n_redir - snap), 64'd1);

    // reset during DRAIN aborts without a CSR write
    issue(1'b1, 1'b0, 64'h80000040, 64'h80000044);
    @(negedge clock);
    check("abort_in_drain", {63'd0, busy}, 64'd1);
    #1 reset = 1'b1;
    #1;
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_flush", {63'd0, flush}, 64'd0);
    check("abort_wb_ready", {63'd0, wb_ready}, 64'd1);
    check("abort_csr_wen", {56'd0, csr_wen}, 64'd0);
    @(posedge clock); #1 reset = 1'b0;
    repeat (5) @(negedge clock);
    check("abort_stays_idle", {63'd0, busy}, 64'd0);

    // vectored mtvec
    mtvec = 64'h80001001; mstatus = 64'h8; mie = 64'h80; timer_irq = 1'b1;
`ifdef YSYX_22050550_TRAP_VECTORED_EN
    vec_exp = 64'h8000101C;
`else
    vec_exp = 64'h80001000;
`endif
    commit_q.push_back('{8'h0B, 64'h80000504, 64'h8000000000000007,
                         64'h80, vec_exp});
    issue(1'b0, 1'b0, 64'h80000500, 64'h80000504);
    wait_idle(bn, fn);
    timer_irq = 1'b0;
    commit_q.push_back('{8'h0B, 64'h80000600, 64'd11, 64'h80, 64'h80001000});
    issue(1'b1, 1'b0, 64'h80000600, 64'h80000604);
    wait_idle(bn, fn);

    repeat (2) @(negedge clock);
    check("commit_q_empty", 64'(commit_q.size()), 64'd0);
    check("redir_q_empty", 64'(redir_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
